// File: rtl/seq_det_sched_pkg.sv
// seq_sched_pkg: shared types and default constants for the sequence-detector
// scheduler and its match engine.
package seq_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      REPORT = 2'd2
   } sched_state_t;

   // Default pattern geometry. The pattern is held in an 8-bit container so
   // that any pattern length up to 8 can slice its default from here.
   localparam int         DEF_PAT_LEN = 3;
   localparam logic [7:0] DEF_PATTERN = 8'b0000_0101;

endpackage

// File: rtl/seq_match_engine.sv
// seq_match_engine: serial pattern matcher shared by all scheduler lanes.
// Holds the bit history, a saturating fill counter and the comparator.
// Build option SEQ_DET_SCHED_OVERLAP_EN: when defined, overlapping matches
// count; otherwise a match restarts the fill so matches never share bits.
module seq_match_engine
   import seq_sched_pkg::*;
#(
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0]
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic shift,
   input  logic bit_in,
   output logic match
);

   localparam int            FW   = $clog2(PAT_LEN + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

   logic [PAT_LEN-1:0] hist_q, hist_d, histShift;
   logic [FW-1:0]      fill_q, fill_d, fillInc;

   // Next history/fill and the match decision; the incoming bit counts
   // toward the match on the same beat it arrives.
   always_comb begin
      hist_d    = hist_q;
      fill_d    = fill_q;
      match     = 1'b0;
      histShift = {hist_q[PAT_LEN-2:0], bit_in};
      fillInc   = (fill_q == FULL) ? FULL : fill_q + FW'(1);
      if (clr) begin
         hist_d = '0;
         fill_d = '0;
      end else if (shift) begin
         hist_d = histShift;
         fill_d = fillInc;
         if ((fillInc == FULL) && (histShift == PATTERN)) begin
            match = 1'b1;
`ifdef SEQ_DET_SCHED_OVERLAP_EN
            fill_d = fillInc;
`else
            fill_d = '0;
`endif
         end
      end
   end

   // History and fill registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler that grants one bit-serial lane per
// packet to a shared pattern-match engine and returns (lane, match count)
// over a valid/ready handshake.
// Build option SEQ_DET_SCHED_OVERLAP_EN selects overlapping match counting
// inside the engine.
module seq_det_sched
   import seq_sched_pkg::*;
#(
   parameter int                 N_REQ   = 4,
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0],
   parameter int                 CNT_W   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_bit,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [$clog2(N_REQ)-1:0]  res_lane,
   output logic [CNT_W-1:0]          res_count,
   output logic                      busy
);

   localparam int LW = $clog2(N_REQ);

   sched_state_t     state_q;
   logic [LW-1:0]    grant_q, rr_ptr_q, res_lane_q;
   logic [CNT_W-1:0] cnt_q, cnt_d, res_count_q;
   logic [N_REQ-1:0] req_ready_q;
   logic             res_valid_q, busy_q;

   logic             pickFound;
   logic [LW-1:0]    pickLane;
   logic             beat, engineClr, engineMatch;

   // Round-robin pick: first valid lane at or above rr_ptr, wrapping around
   always_comb begin
      pickFound = 1'b0;
      pickLane  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!pickFound && req_valid[(int'(rr_ptr_q) + i) % N_REQ]) begin
            pickFound = 1'b1;
            pickLane  = LW'((int'(rr_ptr_q) + i) % N_REQ);
         end
      end
   end

   // Beat qualification and engine control; non-granted lanes never reach here
   always_comb begin
      beat      = (state_q == STREAM) && req_valid[grant_q] && req_ready_q[grant_q];
      engineClr = (state_q == IDLE) && pickFound;
      cnt_d     = cnt_q;
      if (engineMatch && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   seq_match_engine #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) u_engine (
      .clk    (clk),
      .rst    (rst),
      .clr    (engineClr),
      .shift  (beat),
      .bit_in (req_bit[grant_q]),
      .match  (engineMatch)
   );

   // Scheduler FSM with registered handshake outputs and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         res_lane_q  <= '0;
         res_count_q <= '0;
         req_ready_q <= '0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pickFound) begin
                  grant_q     <= pickLane;
                  cnt_q       <= '0;
                  req_ready_q <= {{(N_REQ-1){1'b0}}, 1'b1} << pickLane;
                  busy_q      <= 1'b1;
                  state_q     <= STREAM;
               end
            end
            STREAM: begin
               if (beat) begin
                  cnt_q <= cnt_d;
                  if (req_last[grant_q]) begin
                     res_lane_q  <= grant_q;
                     res_count_q <= cnt_d;
                     res_valid_q <= 1'b1;
                     req_ready_q <= '0;
                     state_q     <= REPORT;
                  end
               end
            end
            REPORT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  rr_ptr_q    <= (grant_q == LW'(N_REQ - 1)) ? '0 : grant_q + LW'(1);
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign res_valid = res_valid_q;
   assign res_lane  = res_lane_q;
   assign res_count = res_count_q;
   assign busy      = busy_q;

endmodule
